// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC sample averager
//
// Holds the channel count, the sample width, the channel address type and
// the FIFO entry layout, which are used by the interface, the FIFO and the top.

package adc_pkg;

  localparam int ADC_NUM_CH = 4;
  localparam int ADC_DATA_W = 8;

  typedef logic [1:0] adc_ch_t;

  typedef struct packed {
    adc_ch_t                 ch;
    logic [ADC_DATA_W-1:0]   data;
  } adc_avg_entry_t;

endpackage

// File: rtl/adc_sample_averager_if.sv
// rtl/adc_sample_averager_if.sv - sample strobe input and averaged result output stream
//
// Signals:
//   sample_valid  single-cycle sample strobe
//   sample_ch     3-bit channel address (only 0..3 are legal)
//   sample_data   8-bit conversion result
//   out_valid     result FIFO non-empty
//   out_ready     consumer accepts the head entry
//   out_ch        channel of the head entry
//   out_data      average at the head entry
// Modports:
//   master  the producer of samples and consumer of results
//   slave   the averager

interface adc_sample_averager_if;
  import adc_pkg::*;

  logic                  sample_valid;
  logic [2:0]            sample_ch;
  logic [ADC_DATA_W-1:0] sample_data;
  logic                  out_valid;
  logic                  out_ready;
  adc_ch_t               out_ch;
  logic [ADC_DATA_W-1:0] out_data;

  modport master (
    output sample_valid, sample_ch, sample_data, out_ready,
    input  out_valid, out_ch, out_data
  );

  modport slave (
    input  sample_valid, sample_ch, sample_data, out_ready,
    output out_valid, out_ch, out_data
  );

endinterface

// File: rtl/adc_avg_fifo.sv
// rtl/adc_avg_fifo.sv - first-word-fall-through FIFO of averaged results
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push, din   write din at the tail (ignored when full unless popping)
//   pop         retire the head entry (ignored when empty)
//   flush       synchronous clear of pointers and count; push/pop ignored
//   full, empty occupancy status
//   head        head entry, all zeros when empty

module adc_avg_fifo
  import adc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  adc_avg_entry_t din,
  input  logic           pop,
  input  logic           flush,
  output logic           full,
  output logic           empty,
  output adc_avg_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  adc_avg_entry_t mem_q [DEPTH];
  logic [PW-1:0]  wr_q, wr_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push, do_pop;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign head  = empty ? '0 : mem_q[rd_q];

  // A push into a full FIFO succeeds only when the head leaves the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// rtl/adc_sample_averager.sv - per-channel block averager with result FIFO
//
// Accumulates 2^LOG2_AVG samples per channel (4 channels) and pushes each
// block average, tagged with its channel, into an output FIFO.
// Optional feature macro: ADC_AVG_ROUND_EN (round-half-up instead of truncate).
// Ports:
//   CLK, RST_N  clock and asynchronous active-low reset
//   bus         sample strobe input and result stream output (slave modport)
//   flush       synchronous clear of accumulators, counters and FIFO
//   clr_flags   synchronous clear of ovf and bad_ch (a same-cycle set wins)
//   ovf         sticky: a result was dropped because the FIFO was full
//   bad_ch      sticky: a strobe arrived with an illegal channel address

module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int LOG2_AVG   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  adc_sample_averager_if.slave   bus,
  input  logic                   flush,
  input  logic                   clr_flags,
  output logic                   ovf,
  output logic                   bad_ch
);

  localparam int N  = 1 << LOG2_AVG;
  localparam int AW = ADC_DATA_W + LOG2_AVG;
  // With LOG2_AVG = 0 the counter is a 1-bit register that never leaves 0,
  // so every sample is the final one of its block.
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [AW-1:0]  acc_q [ADC_NUM_CH];
  logic [AW-1:0]  acc_d [ADC_NUM_CH];
  logic [CW-1:0]  cnt_q [ADC_NUM_CH];
  logic [CW-1:0]  cnt_d [ADC_NUM_CH];
  logic           ovf_q, ovf_d;
  logic           bad_q, bad_d;

  logic           ch_legal, accept, is_final, push, drop;
  adc_ch_t        ch;
  logic [AW-1:0]  sum, sum_rnd, shifted;
  adc_avg_entry_t push_entry, head;
  logic           fifo_full, fifo_empty;

  assign ch       = bus.sample_ch[1:0];
  assign ch_legal = ~bus.sample_ch[2];
  assign accept   = bus.sample_valid & ch_legal & ~flush;
  assign is_final = (cnt_q[ch] == CNT_LAST);
  assign push     = accept & is_final;

  // acc never exceeds 255*(N-1), so adding one more sample cannot overflow AW.
  assign sum = acc_q[ch] + AW'(bus.sample_data);

`ifdef ADC_AVG_ROUND_EN
  // Largest rounded sum is 255*N + N/2 < 256*N, still inside AW bits.
  assign sum_rnd = sum + AW'(N >> 1);
`else
  assign sum_rnd = sum;
`endif

  assign shifted    = sum_rnd >> LOG2_AVG;
  assign push_entry = '{ch: ch, data: shifted[ADC_DATA_W-1:0]};

  // Drop only when full and the head is not leaving this same cycle.
  assign drop = push & fifo_full & ~(bus.out_ready & ~fifo_empty);

  always_comb begin
    for (int c = 0; c < ADC_NUM_CH; c++) begin
      acc_d[c] = acc_q[c];
      cnt_d[c] = cnt_q[c];
    end
    if (flush) begin
      for (int c = 0; c < ADC_NUM_CH; c++) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
      end
    end else if (accept) begin
      if (is_final) begin
        acc_d[ch] = '0;
        cnt_d[ch] = '0;
      end else begin
        acc_d[ch] = sum;
        cnt_d[ch] = cnt_q[ch] + 1'b1;
      end
    end
  end

  always_comb begin
    ovf_d = (ovf_q & ~clr_flags) | drop;
    bad_d = (bad_q & ~clr_flags) | (bus.sample_valid & ~ch_legal & ~flush);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int c = 0; c < ADC_NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      ovf_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      for (int c = 0; c < ADC_NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      ovf_q <= ovf_d;
      bad_q <= bad_d;
    end
  end

  adc_avg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .din   (push_entry),
    .pop   (bus.out_ready),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_ch    = head.ch;
  assign bus.out_data  = head.data;
  assign ovf           = ovf_q;
  assign bad_ch        = bad_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// tb/tb_adc_sample_averager.sv - self-checking bench for adc_sample_averager

module tb_adc_sample_averager;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic flush;
  logic clr_flags;
  logic ovf;
  logic bad_ch;

  adc_sample_averager_if bus ();

  adc_sample_averager #(
    .LOG2_AVG   (2),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .clr_flags (clr_flags),
    .ovf       (ovf),
    .bad_ch    (bad_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: running per-channel sums/counts and a queue of
  // pending results encoded as ch*256 + data.
  int ms [4];
  int mn [4];
  int mq [$];
  bit m_ovf;
  bit m_bad;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      ms[c] = 0;
      mn[c] = 0;
    end
    mq.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
  endtask

  task automatic model_update(bit v, int ch, int d, bit rdy, bit fl, bit clr);
    bit popped;
    bit pushing;
    int avg;
    if (clr) begin
      m_ovf = 1'b0;
      m_bad = 1'b0;
    end
    if (fl) begin
      for (int c = 0; c < 4; c++) begin
        ms[c] = 0;
        mn[c] = 0;
      end
      mq.delete();
      return;
    end
    popped  = rdy && (mq.size() > 0);
    pushing = 1'b0;
    avg     = 0;
    if (v && ch > 3) begin
      m_bad = 1'b1;
    end else if (v) begin
      ms[ch] += d;
      mn[ch]++;
      if (mn[ch] == N) begin
`ifdef ADC_AVG_ROUND_EN
        avg = (ms[ch] + N / 2) / N;
`else
        avg = ms[ch] / N;
`endif
        if (mq.size() - int'(popped) < DEPTH) pushing = 1'b1;
        else m_ovf = 1'b1;
        ms[ch] = 0;
        mn[ch] = 0;
      end
    end
    if (popped) void'(mq.pop_front());
    if (pushing) mq.push_back(ch * 256 + avg);
  endtask

  task automatic compare_all();
    int hd;
    hd = (mq.size() > 0) ? mq[0] : 0;
    chk("out_valid", int'(bus.out_valid), int'(mq.size() > 0));
    chk("out_ch", int'(bus.out_ch), hd / 256);
    chk("out_data", int'(bus.out_data), hd % 256);
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("bad_ch", int'(bad_ch), int'(m_bad));
  endtask

  task automatic step(bit v, int ch, int d, bit rdy, bit fl, bit clr);
    bus.sample_valid = v;
    bus.sample_ch    = 3'(ch);
    bus.sample_data  = 8'(d);
    bus.out_ready    = rdy;
    flush            = fl;
    clr_flags        = clr;
    @(posedge clk);
    model_update(v, ch, d, rdy, fl, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.sample_valid = 1'b0;
    bus.sample_ch    = '0;
    bus.sample_data  = '0;
    bus.out_ready    = 1'b0;
    flush            = 1'b0;
    clr_flags        = 1'b0;
  endtask

  // Assert reset between edges, hold it with random inputs, then release.
  task automatic reset_pulse(int ncyc);
    #2;
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < ncyc; i++) begin
      bus.sample_valid = 1'($urandom);
      bus.sample_ch    = 3'($urandom);
      bus.sample_data  = 8'($urandom);
      bus.out_ready    = 1'($urandom);
      flush            = 1'($urandom);
      clr_flags        = 1'($urandom);
      @(negedge clk);
      compare_all();
    end
    idle_inputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain(int exp_pops);
    int pops;
    pops = 0;
    for (int i = 0; i < 10 && bus.out_valid; i++) begin
      pops++;
      step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_pops", pops, exp_pops);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_clear();

    // Reset with random inputs: everything reads zero.
    reset_pulse(5);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_bad_ch", int'(bad_ch), 0);

    // Channel 1: 10,20,30,40 -> 25 one cycle after the final sample.
    step(1'b1, 1, 10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 30, 1'b0, 1'b0, 1'b0);
    chk("no_early_valid", int'(bus.out_valid), 0);
    step(1'b1, 1, 40, 1'b0, 1'b0, 1'b0);
    chk("avg25_valid", int'(bus.out_valid), 1);
    chk("avg25_ch", int'(bus.out_ch), 1);
    chk("avg25_data", int'(bus.out_data), 25);
    chk("model_avg25", (mq.size() > 0) ? mq[0] : -1, 256 + 25);
    drain(1);

    // Channel 0: 1,1,2,2 -> 1.5, truncated or rounded.
    step(1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
`ifdef ADC_AVG_ROUND_EN
    chk("avg_round", int'(bus.out_data), 2);
`else
    chk("avg_trunc", int'(bus.out_data), 1);
`endif
    drain(1);

    // Fill the FIFO with four interleaved blocks, then overflow it.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        step(1'b1, c, int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    chk("full_occupancy", mq.size(), 4);
    chk("full_head_ch", int'(bus.out_ch), 0);
    chk("full_ovf", int'(ovf), 0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 0, 100, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf", int'(ovf), 1);
    chk("drop_occupancy", mq.size(), 4);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", int'(ovf), 0);

    // Full FIFO, final sample with a simultaneous pop: both succeed.
    step(1'b1, 1, 7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1, 7, 1'b1, 1'b0, 1'b0);
    chk("pushpop_ovf", int'(ovf), 0);
    chk("pushpop_tail", (mq.size() == 4) ? mq[3] : -1, 256 + 7);
    drain(4);

    // Partial block lost to a mid-block reset.
    step(1'b1, 2, 50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2, 60, 1'b0, 1'b0, 1'b0);
    reset_pulse(2);
    for (int i = 0; i < 4; i++)
      step(1'b1, 2, 8, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", int'(bus.out_data), 8);
    chk("post_rst_ch", int'(bus.out_ch), 2);
    step(1'b1, 5, 99, 1'b1, 1'b0, 1'b0);
    chk("bad_ch_set", int'(bad_ch), 1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 2, 12, 1'b0, 1'b0, 1'b0);
    chk("bad_no_acc", int'(bus.out_data), 12);
    drain(1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("clr_bad_ch", int'(bad_ch), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit v, rdy, fl, clr;
      int ch;
      v   = ($urandom_range(0, 99) < 70);
      ch  = ($urandom_range(0, 99) < 5) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 80));
      fl  = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 49) == 0);
      step(v, ch, int'($urandom_range(0, 255)), rdy, fl, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_averager.md
# adc_sample_averager

Downstream consumer of the ADC scan controller's sample stream. It takes one 8-bit conversion result per strobe, tagged with its channel address, and accumulates 2^LOG2_AVG samples per channel in independent per-channel accumulators. Each completed block average goes into a small output FIFO, tagged with its channel, and is drained through a valid/ready handshake to the data-logging or display stage.

## Interface
- LOG2_AVG, default 2: log2 of samples per average; legal range 0..4.
- FIFO_DEPTH, default 4: output FIFO entries; must be a power of two.
- CLK  input  1  single clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- sample_valid  input  1  single-cycle strobe; sample_ch and sample_data are valid this cycle.
- sample_ch  input  3  channel address of the sample; only 0..3 are legal.
- sample_data  input  8  conversion result.
- flush  input  1  synchronous clear of all accumulators, counters and the FIFO.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry.
- out_ch  output  2  channel of the head entry.
- out_data  output  8  average at the head entry.
- ovf  output  1  sticky: a result was dropped because the FIFO was full.
- bad_ch  output  1  sticky: a strobe arrived with sample_ch > 3.
- clr_flags  input  1  synchronous clear of ovf and bad_ch.

## Operation
- Per channel c in 0..3:
  - acc[c] is 8+LOG2_AVG bits wide.
  - cnt[c] is LOG2_AVG bits wide.
- Sample accept, when sample_valid=1, sample_ch<4 and flush=0:
  - If cnt[c] < 2^LOG2_AVG−1: acc[c] += sample_data and cnt[c]++.
  - Otherwise this is the final sample of the block:
    - sum = acc[c] + sample_data.
    - result = sum >> LOG2_AVG (see Configuration for rounding).
    - Push {c, result} into the FIFO.
    - acc[c] and cnt[c] go to 0.
- LOG2_AVG=0: every accepted sample is pushed unchanged.
- sample_valid=1 with sample_ch ≥ 4: no state change except bad_ch ← 1.
- FIFO full at push time:
  - Without a pop the same cycle: result discarded, ovf ← 1, and the accumulator still clears.
  - With a pop the same cycle (out_valid & out_ready): pop and push both succeed and occupancy is unchanged.
- Pop: on out_valid & out_ready, the head entry retires.
- Output is first-word-fall-through: out_ch and out_data show the head entry whenever out_valid=1, and are 0 when the FIFO is empty.
- flush=1:
  - Clears all acc, cnt and FIFO pointers. Any sample or pop in that cycle is ignored.
  - Does not clear ovf or bad_ch.
- clr_flags and a same-cycle flag-set event: set wins.

## Timing
- Reset values: out_valid=0, out_ch=0, out_data=0, ovf=0, bad_ch=0. All acc, cnt and pointers are 0.
- Reset asserted mid-block: all partial sums are lost, and the next block starts at cnt=0 after release.
- Latency: out_valid rises on the first edge after the edge that accepted the final sample of a block (1 cycle) when the FIFO was empty.
- Throughput:
  - One sample per cycle on any channel mix.
  - One pop per cycle.
- Back-to-back strobes on the same channel are legal.
- FIFO occupancy: count bits = log2(FIFO_DEPTH)+1.
  - full = (count == FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.

## Configuration
- ADC_AVG_ROUND_EN defined: result = (sum + 2^(LOG2_AVG−1)) >> LOG2_AVG for LOG2_AVG ≥ 1, i.e. round-half-up.
  - The maximum sum is 255·N + N/2 < 256·N, so no extra width is needed and the result never exceeds 255.
- ADC_AVG_ROUND_EN undefined: result = sum >> LOG2_AVG (truncation).

## Structure
- Shared package adc_pkg holds:
  - ADC_NUM_CH = 4 and ADC_DATA_W = 8.
  - Typedef adc_ch_t (2-bit).
  - Packed struct adc_avg_entry_t {ch, data}.
- Sub-module adc_avg_fifo: synchronous FWFT FIFO of adc_avg_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Simultaneous push/pop when full is legal.
- The top level holds the accumulator bank, the final-sample detect, the rounding and the flags.

## Test plan
- Reset: hold RST_N=0 with random inputs → all outputs 0. After release, no out_valid until a block completes.
- LOG2_AVG=2, channel 1 samples 10, 20, 30, 40 on consecutive cycles → one cycle later: out_valid=1, out_ch=1, out_data=25.
- Samples 1, 1, 2, 2 on channel 0 → out_data=1 without ADC_AVG_ROUND_EN; out_data=2 with it.
- out_ready=0, channels 0..3 interleaved, four samples each → FIFO full with four entries in completion order, ovf=0. A fifth completed block → dropped, ovf=1. Then clr_flags → ovf=0.
- FIFO full, out_ready=1 on the same cycle as a final sample → occupancy stays at 4, ovf stays 0, new entry is at the tail.
- Two samples on channel 2, pulse RST_N low, then 8, 8, 8, 8 on channel 2 → out_data=8. A strobe with sample_ch=5 → bad_ch=1 and no accumulator change.
